// File: rtl/mlt_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings
// used by the controller and by the testbench for state checks.
// Build option: MLT_SIGNED_EN selects two's-complement operands (see top).
package mlt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } mlt_state_t;

endpackage

// File: rtl/mlt_sa_ctrl.sv
// Sequencer for the shift-and-add multiplier: IDLE -> CALC (WIDTH steps) ->
// FIN (1 cycle) -> IDLE. Emits ld/step/fin strobes for the datapath.
// Build option: MLT_SIGNED_EN adds a 'last' strobe marking the final step.
module mlt_sa_ctrl
    import mlt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    output logic ld,
    output logic step,
    output logic fin
`ifdef MLT_SIGNED_EN
    ,
    output logic last
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mlt_state_t        state;
    mlt_state_t        state_nx;
    logic [CNT_W-1:0]  cnt;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Iteration counter: loaded with WIDTH on accept, decremented per step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   cnt <= '0;
        else if (ld)   cnt <= CNT_W'(WIDTH);
        else if (step) cnt <= cnt - CNT_W'(1);
    end

    // Next-state and strobe decode.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    ld       = 1'b1;
                    state_nx = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) state_nx = ST_FIN;
            end
            ST_FIN: begin
                fin      = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef MLT_SIGNED_EN
    // Final step carries the multiplier sign bit and must subtract.
    assign last = (state == ST_CALC) && (cnt == CNT_W'(1));
`endif

endmodule

// File: rtl/shift_add_mlt_top.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier
// bit per clock, fixed latency. Datapath lives here; sequencing in mlt_sa_ctrl.
// Build option: define MLT_SIGNED_EN for two's-complement operands and result;
// default build is unsigned.
module shift_add_mlt_top
    import mlt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   ain,
    input  logic [WIDTH-1:0]   bin,
    output logic [2*WIDTH-1:0] data_op,
    output logic               busy,
    output logic               done,
    output logic               zero
);

    logic             ld;
    logic             step;
    logic             fin;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [WIDTH:0]   ext_p;
    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   sum;

`ifdef MLT_SIGNED_EN
    logic last;

    mlt_sa_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .ld     (ld),
        .step   (step),
        .fin    (fin),
        .last   (last)
    );

    // Sign-extended partial sum; the MSB step subtracts (its weight is negative).
    always_comb begin
        ext_p = {p_hi[WIDTH-1], p_hi};
        ext_a = {a_q[WIDTH-1], a_q};
        sum   = ext_p;
        if (b_q[0]) sum = last ? (ext_p - ext_a) : (ext_p + ext_a);
    end
`else
    mlt_sa_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .ld     (ld),
        .step   (step),
        .fin    (fin)
    );

    // Zero-extended partial sum; the extra bit holds the carry.
    always_comb begin
        ext_p = {1'b0, p_hi};
        ext_a = {1'b0, a_q};
        sum   = ext_p;
        if (b_q[0]) sum = ext_p + ext_a;
    end
`endif

    // Operand and partial-product registers: load on accept, shift right each step.
    // NOTE: these are reloaded on every accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (ld) begin
            a_q  <= ain;
            b_q  <= bin;
            p_hi <= '0;
            p_lo <= '0;
        end else if (step) begin
            p_hi <= sum[WIDTH:1];
            p_lo <= {sum[0], p_lo[WIDTH-1:1]};
            b_q  <= b_q >> 1;
        end
    end

    // Visible outputs: result, zero flag and done pulse update together; busy brackets the op.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_op <= '0;
            zero    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ld) busy <= 1'b1;
            if (fin) begin
                data_op <= {p_hi, p_lo};
                zero    <= ({p_hi, p_lo} == '0);
                done    <= 1'b1;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mlt_top.sv
// Self-checking bench for shift_add_mlt_top (WIDTH=16): directed cases plus
// random operands compared against an arithmetic reference product.
// Honours MLT_SIGNED_EN the same way as the design.
module tb_shift_add_mlt_top;
    import mlt_pkg::*;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] ain = '0;
    logic [W-1:0] bin = '0;
    logic [2*W-1:0] data_op;
    logic         busy;
    logic         done;
    logic         zero;

    int total = 0;
    int bad   = 0;

    shift_add_mlt_top #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .ain     (ain),
        .bin     (bin),
        .data_op (data_op),
        .busy    (busy),
        .done    (done),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MLT_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return (2*W)'(sa * sb);
`else
        return (2*W)'(longint'(a) * longint'(b));
`endif
    endfunction

    // One operation; 'intrude' > 0 raises a second start (7 x 7) on that edge after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int intrude);
        logic [2*W-1:0] exp;
        int edges;
        exp = model(a, b);
        @(negedge clk);
        start = 1'b1;
        ain   = a;
        bin   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        ain   = W'($urandom);
        bin   = W'($urandom);
        check("busy_at_accept", 64'(busy), 64'd1);
        check("done_at_accept", 64'(done), 64'd0);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
            if (edges == W) check("busy_before_done", 64'(busy), 64'd1);
            if (intrude > 0 && edges == intrude - 1) begin
                start = 1'b1;
                ain   = 16'd7;
                bin   = 16'd7;
            end
            if (intrude > 0 && edges == intrude) start = 1'b0;
        end
        check("latency", 64'(edges), 64'(LAT));
        check("product", 64'(data_op), 64'(exp));
        check("zero_flag", 64'(zero), 64'(exp == '0));
        check("busy_after_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("done_width", 64'(done), 64'd0);
        check("result_hold", 64'(data_op), 64'(exp));
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_data_op", 64'(data_op), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_state", 64'(u_dut.u_ctrl.state), 64'(ST_IDLE));
        @(negedge clk);
        resetn = 1'b1;

        // Directed cases.
        run_op(16'd3, 16'd5, 0);
        check("const_3x5", 64'(data_op), 64'h0000000F);
        run_op(16'hFFFF, 16'hFFFF, 0);
`ifdef MLT_SIGNED_EN
        check("const_ffff", 64'(data_op), 64'h00000001);
`else
        check("const_ffff", 64'(data_op), 64'hFFFE0001);
`endif
        run_op(16'h8000, 16'd2, 0);
`ifdef MLT_SIGNED_EN
        check("const_8000x2", 64'(data_op), 64'hFFFF0000);
`else
        check("const_8000x2", 64'(data_op), 64'h00010000);
`endif
        run_op(16'h1234, 16'd0, 0);
        check("const_zero", 64'(zero), 64'd1);
        run_op(16'h00AB, 16'h0102, 5);

        // Reset mid-operation: prior result nonzero, must clear at once with no done.
        run_op(16'd9, 16'd11, 0);
        @(negedge clk);
        start = 1'b1;
        ain   = 16'h4321;
        bin   = 16'h1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("abort_data_op", 64'(data_op), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_zero", 64'(zero), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 64'(done), 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_op(16'h00FF, 16'h0101, 0);

        // Random operands, including occasional intruding start requests.
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), (i % 4 == 0) ? int'($urandom_range(2, 15)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
